// File: rtl/rr_mux4_sched.sv
// rr_mux4_sched: round-robin scheduler for a shared single-bit 4:1 mux.
// Each grant is held for a fixed burst of BURST cycles, or until the grantee
// drops its request. After that the next requester in rotation is granted.
// The selected data bit is forwarded on dout, qualified by busy.
module rr_mux4_sched #(
    parameter int BURST = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       dout,
    output logic       done
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Reload value for the burst counter (counter is 8 bits wide).
    localparam logic [7:0] BURST_M1 = 8'(BURST - 1);

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] sel_nxt;
    logic [3:0] gnt_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       arb;
    logic       found;
    logic [1:0] win;

    // Round-robin search starting just after the last grantee; the last grantee is tried last.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment,
        // so no path leaves a value unassigned and no latch is inferred.
        found = 1'b0;
        win   = ptr;
        for (int k = 1; k <= 4; k++) begin
            if (!found && req[ptr + 2'(k)]) begin
                found = 1'b1;
                win   = ptr + 2'(k);
            end
        end
    end

    // Arbitrate when idle, when the burst ends, or when the grantee withdraws.
    always_comb begin
        arb = (state == IDLE) || (cnt == 8'd0) || !req[sel];
    end

    // State register plus the grant/select/pointer/counter datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd3;
            sel   <= 2'd0;
            gnt   <= 4'b0000;
            cnt   <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together
            // from values sampled at the same edge.
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
            gnt   <= gnt_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: grant a winner, drop to idle, or keep counting down the burst.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        gnt_nxt   = gnt;
        cnt_nxt   = cnt;
        if (arb) begin
            if (found) begin
                state_nxt = XFER;
                ptr_nxt   = win;
                sel_nxt   = win;
                gnt_nxt   = 4'b0001 << win;
                cnt_nxt   = BURST_M1;
            end else begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                cnt_nxt   = 8'd0;
            end
        end else begin
            cnt_nxt = cnt - 8'd1;
        end
    end

    // Outputs decoded from registers; dout passes the selected bit straight through.
    always_comb begin
        busy = (state == XFER);
        dout = busy && din[sel];
        done = busy && (cnt == 8'd0) && req[sel];
    end

endmodule
